move_sequencer: RTL

- Sits directly downstream of the setup-move generator. Accepts its 200-bit packed move word on the new_moves strobe and issues the moves one at a time to the face-turn motor driver over a valid/ready handshake.
- Inserts a mechanical settle delay after every turn.
- Holds one further word in a pending buffer and reports seq_done when a word is fully executed, which tells the controller to request the next batch.

---
 rtl/move_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// move_sequencer: issues the 4-bit moves of a packed word one at a time over valid/ready, settling after each turn.
// Optional MOVE_SEQ_COUNT_EN adds the move_total handshake counter.
module move_sequencer #(
    parameter int SLOTS         = 50,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CNT_W         = 20
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4*SLOTS-1:0] moves,
    input  logic               new_moves,
    input  logic               move_ready,
    output logic [3:0]         move_code,
    output logic               move_valid,
    output logic               busy,
    output logic               seq_done,
    output logic               pending_full,
    output logic               overflow,
    output logic               bad_move
`ifdef MOVE_SEQ_COUNT_EN
    ,
    output logic [15:0]        move_total
`endif
);
    localparam int IDX_W = SLOTS > 1 ? $clog2(SLOTS) : 1;

    typedef enum logic [2:0] {IDLE, SCAN, ISSUE, SETTLE, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [4*SLOTS-1:0] r_a, r_p;
    logic               r_p_full;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_code;
    logic               r_valid, r_ovf, r_bad;
    logic [3:0]         w_slot;
    logic               w_slot_ok, w_slot_bad, w_fire, w_shift, w_settled;
    logic               w_load_a, w_load_p, w_from_p, w_drop, w_running;

    // The active word shifts left as slots are consumed, so the slot under examination is always the top nibble.
    assign w_slot     = r_a[4*SLOTS-1 -: 4];
    assign w_slot_ok  = (w_slot >= 4'd2) && (w_slot <= 4'd13);
    assign w_slot_bad = (w_slot == 4'd1) || (w_slot >= 4'd14);
    assign w_fire     = (r_state == ISSUE) && r_valid && move_ready;
    assign w_settled  = (r_state == SETTLE) && (r_cnt == '0);
    assign w_shift    = ((r_state == SCAN) && !w_slot_ok) || w_settled;
    assign w_running  = (r_state == SCAN) || (r_state == ISSUE) || (r_state == SETTLE);

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_a    = 1'b0;
        w_from_p    = 1'b0;
        w_load_p    = new_moves && w_running && !r_p_full;
        w_drop      = new_moves && w_running && r_p_full;
        case (r_state)
            IDLE: begin
                w_load_a    = new_moves;
                w_state_nxt = new_moves ? SCAN : IDLE;
            end
            SCAN:   w_state_nxt = w_slot_ok ? ISSUE : (r_idx == '0 ? DONE : SCAN);
            ISSUE:  w_state_nxt = w_fire ? SETTLE : ISSUE;
            SETTLE: w_state_nxt = (r_cnt != '0) ? SETTLE : (r_idx == '0 ? DONE : SCAN);
            DONE: begin
                // A strobe landing here refills P after the transfer, or starts A directly when P was empty.
                w_from_p    = r_p_full;
                w_load_p    = r_p_full && new_moves;
                w_load_a    = !r_p_full && new_moves;
                w_state_nxt = (r_p_full || new_moves) ? SCAN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a      <= '0;
            r_p      <= '0;
            r_p_full <= 1'b0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_code   <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            if (w_load_a)
                r_a <= moves;
            else if (w_from_p)
                r_a <= r_p;
            else if (w_shift)
                r_a <= r_a << 4;
            if (w_load_a || w_from_p)
                r_idx <= IDX_W'(SLOTS - 1);
            else if (w_shift)
                r_idx <= r_idx - 1'b1;
            if (w_load_p) begin
                r_p      <= moves;
                r_p_full <= 1'b1;
            end else if (w_from_p) begin
                r_p      <= '0;
                r_p_full <= 1'b0;
            end
            if ((r_state == SCAN) && w_slot_ok) begin
                r_code  <= w_slot;
                r_valid <= 1'b1;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end
            if (w_fire)
                r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
            else if ((r_state == SETTLE) && (r_cnt != '0))
                r_cnt <= r_cnt - 1'b1;
            r_ovf <= r_ovf | w_drop;
            r_bad <= r_bad | ((r_state == SCAN) && w_slot_bad);
        end
    end

`ifdef MOVE_SEQ_COUNT_EN
    logic [15:0] r_total;

    always_ff @(posedge clock) begin
        if (reset)
            r_total <= '0;
        else if (w_fire)
            r_total <= r_total + 16'd1;
    end

    assign move_total = r_total;
`endif

    assign move_code    = r_code;
    assign move_valid   = r_valid;
    assign busy         = (r_state != IDLE);
    assign seq_done     = (r_state == DONE);
    assign pending_full = r_p_full;
    assign overflow     = r_ovf;
    assign bad_move     = r_bad;
endmodule
